// File: rtl/uart_baud_cfg_ctrl_if.sv
// Configuration request channel between the APB register file and the baud
// configuration sequencer: valid/ready request plus done/error completion pulses.
interface uart_baud_cfg_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [12:0] cfg_baud_val;
  logic [2:0]  cfg_frac;
  logic        cfg_done;
  logic        cfg_err;

  modport master (
    output cfg_valid, cfg_baud_val, cfg_frac,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_baud_val, cfg_frac,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/uart_baud_cfg_ctrl.sv
// Run-time baud reconfiguration for the CoreUARTapb clock generator: waits for
// an idle line and a bit boundary, applies the new divider, restarts the generator.
module uart_baud_cfg_ctrl #(
  parameter bit          FRCTN_EN       = 1'b0,
  parameter logic [12:0] RESET_BAUD_VAL = 13'd1,
  parameter logic [2:0]  RESET_FRAC     = 3'd0,
  parameter logic [15:0] IDLE_TIMEOUT   = 16'd0,
  parameter int unsigned RESTART_CYCLES = 2,
  parameter int unsigned SETTLE_TICKS   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  uart_baud_cfg_ctrl_if.slave        cfg,
  input  logic                       tx_busy,
  input  logic                       rx_busy,
  input  logic                       xmit_pulse,
  input  logic                       baud_clock,
  output logic [12:0]                baud_val,
  output logic [2:0]                 baud_val_fraction,
  output logic                       gen_reset_n,
  output logic                       busy
);

  localparam int unsigned RST_W  = $clog2(RESTART_CYCLES + 1);
  localparam int unsigned TICK_W = $clog2(SETTLE_TICKS + 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESTART_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SETTLE_TICKS - 1);
  localparam logic [2:0]        FRAC_RST  = FRCTN_EN ? RESET_FRAC : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_EDGE,
    S_APPLY,
    S_RESTART,
    S_SETTLE
  } state_t;

  state_t            state;
  logic [15:0]       to_cnt;
  logic [RST_W-1:0]  rst_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [12:0]       sh_baud;
  logic [2:0]        sh_frac;
  logic              done_q;
  logic              err_q;

  logic [2:0]  eff_frac;
  logic [15:0] to_cnt_inc;
  logic        line_busy;

  assign eff_frac   = FRCTN_EN ? cfg.cfg_frac : 3'd0;
  assign to_cnt_inc = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
  assign line_busy  = tx_busy | rx_busy;

  assign cfg.cfg_ready = (state == S_IDLE);
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
  assign busy          = (state != S_IDLE);

  // NOTE: all state below is updated with <= so every branch sees the pre-edge
  // values; the shadow registers are plain flops, so they are reset too.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      baud_val          <= RESET_BAUD_VAL;
      baud_val_fraction <= FRAC_RST;
      gen_reset_n       <= 1'b0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      to_cnt            <= '0;
      rst_cnt           <= '0;
      tick_cnt          <= '0;
      sh_baud           <= '0;
      sh_frac           <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          gen_reset_n <= 1'b1;
          if (cfg.cfg_valid) begin
            sh_baud <= cfg.cfg_baud_val;
            sh_frac <= eff_frac;
            // A zero divider with a fraction has no meaning to the generator.
            if (cfg.cfg_baud_val == 13'd0 && eff_frac != 3'd0) begin
              err_q <= 1'b1;
            end else begin
              to_cnt <= '0;
              state  <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          to_cnt <= to_cnt_inc;
          if (!line_busy) begin
            state <= S_WAIT_EDGE;
          end else if (IDLE_TIMEOUT != 16'd0 && to_cnt_inc == IDLE_TIMEOUT) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WAIT_EDGE: begin
          // Busy wins over a coincident bit boundary; the timeout keeps accumulating.
          if (line_busy) begin
            state <= S_WAIT_IDLE;
          end else if (xmit_pulse) begin
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          baud_val          <= sh_baud;
          baud_val_fraction <= sh_frac;
          gen_reset_n       <= 1'b0;
          rst_cnt           <= '0;
          state             <= S_RESTART;
        end
        S_RESTART: begin
          if (rst_cnt == RST_LAST) begin
            gen_reset_n <= 1'b1;
            tick_cnt    <= '0;
            state       <= S_SETTLE;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        S_SETTLE: begin
          if (baud_clock) begin
            if (tick_cnt == TICK_LAST) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
// Bench for uart_baud_cfg_ctrl: two differently parameterised instances share one
// stimulus stream and are compared every cycle against an event-level model.
module tb_uart_baud_cfg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n    = 1'b0;
  logic        tx_busy    = 1'b0;
  logic        rx_busy    = 1'b0;
  logic        xmit_pulse = 1'b0;
  logic        baud_clock = 1'b0;
  logic        cfg_valid  = 1'b0;
  logic [12:0] cfg_bv     = '0;
  logic [2:0]  cfg_fr     = '0;

  uart_baud_cfg_ctrl_if if_a ();
  uart_baud_cfg_ctrl_if if_b ();

  assign if_a.cfg_valid    = cfg_valid;
  assign if_a.cfg_baud_val = cfg_bv;
  assign if_a.cfg_frac     = cfg_fr;
  assign if_b.cfg_valid    = cfg_valid;
  assign if_b.cfg_baud_val = cfg_bv;
  assign if_b.cfg_frac     = cfg_fr;

  logic [12:0] bv_a, bv_b;
  logic [2:0]  fr_a, fr_b;
  logic        grn_a, grn_b, busy_a, busy_b;

  uart_baud_cfg_ctrl #(
    .FRCTN_EN(1'b1), .RESET_BAUD_VAL(13'd1), .RESET_FRAC(3'd0),
    .IDLE_TIMEOUT(16'd100), .RESTART_CYCLES(2), .SETTLE_TICKS(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .cfg(if_a.slave),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .xmit_pulse(xmit_pulse), .baud_clock(baud_clock),
    .baud_val(bv_a), .baud_val_fraction(fr_a), .gen_reset_n(grn_a), .busy(busy_a)
  );

  uart_baud_cfg_ctrl #(
    .FRCTN_EN(1'b0), .RESET_BAUD_VAL(13'd100), .RESET_FRAC(3'd5),
    .IDLE_TIMEOUT(16'd0), .RESTART_CYCLES(1), .SETTLE_TICKS(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .cfg(if_b.slave),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .xmit_pulse(xmit_pulse), .baud_clock(baud_clock),
    .baud_val(bv_b), .baud_val_fraction(fr_b), .gen_reset_n(grn_b), .busy(busy_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-instance configuration, index 0 = dut_a, 1 = dut_b.
  int p_fen[2] = '{1, 0};
  int p_rbv[2] = '{1, 100};
  int p_rfr[2] = '{0, 5};
  int p_to[2]  = '{100, 0};
  int p_rc[2]  = '{2, 1};
  int p_st[2]  = '{16, 4};

  // Model: a request is "pending" until applied, "quiet" once the line was seen idle,
  // then counts down restart cycles and settle ticks.
  int m_bv[2], m_fr[2], m_sbv[2], m_sfr[2], m_low[2], m_ticks[2], m_waited[2];
  bit m_grn[2], m_done[2], m_err[2], m_pend[2], m_quiet[2], m_apply[2];

  function automatic bit in_flight(input int k);
    return m_pend[k] || m_apply[k] || m_low[k] > 0 || m_ticks[k] > 0;
  endfunction

  task automatic model_step(input int k);
    int eff;
    m_done[k] = 1'b0;
    m_err[k]  = 1'b0;
    if (!reset_n) begin
      m_bv[k] = p_rbv[k];
      m_fr[k] = p_fen[k] != 0 ? p_rfr[k] : 0;
      m_grn[k] = 1'b0;
      m_pend[k] = 1'b0; m_quiet[k] = 1'b0; m_apply[k] = 1'b0;
      m_low[k] = 0; m_ticks[k] = 0; m_waited[k] = 0;
      return;
    end
    if (!in_flight(k)) begin
      m_grn[k] = 1'b1;
      if (cfg_valid) begin
        eff = p_fen[k] != 0 ? int'(cfg_fr) : 0;
        m_sbv[k] = int'(cfg_bv);
        m_sfr[k] = eff;
        if (cfg_bv == 13'd0 && eff != 0) m_err[k] = 1'b1;
        else begin
          m_pend[k] = 1'b1; m_quiet[k] = 1'b0; m_waited[k] = 0;
        end
      end
    end else if (m_pend[k]) begin
      if (!m_quiet[k]) begin
        m_waited[k]++;
        if (!tx_busy && !rx_busy) m_quiet[k] = 1'b1;
        else if (p_to[k] != 0 && m_waited[k] == p_to[k]) begin
          m_pend[k] = 1'b0;
          m_err[k]  = 1'b1;
        end
      end else if (tx_busy || rx_busy) begin
        m_quiet[k] = 1'b0;
      end else if (xmit_pulse) begin
        m_pend[k]  = 1'b0;
        m_apply[k] = 1'b1;
      end
    end else if (m_apply[k]) begin
      m_bv[k] = m_sbv[k];
      m_fr[k] = m_sfr[k];
      m_grn[k] = 1'b0;
      m_apply[k] = 1'b0;
      m_low[k] = p_rc[k];
    end else if (m_low[k] > 0) begin
      m_low[k]--;
      if (m_low[k] == 0) begin
        m_grn[k] = 1'b1;
        m_ticks[k] = p_st[k];
      end
    end else if (baud_clock) begin
      m_ticks[k]--;
      if (m_ticks[k] == 0) m_done[k] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic compare_one(input int k, input logic [12:0] bv, input logic [2:0] fr,
                             input logic grn, input logic rdy, input logic dn,
                             input logic er, input logic bsy);
    string t;
    t = (k != 0) ? "b" : "a";
    check({t, ".baud_val"},    32'(bv),  32'(m_bv[k]));
    check({t, ".fraction"},    32'(fr),  32'(m_fr[k]));
    check({t, ".gen_reset_n"}, 32'(grn), 32'(m_grn[k]));
    check({t, ".cfg_ready"},   32'(rdy), 32'(!in_flight(k)));
    check({t, ".busy"},        32'(bsy), 32'(in_flight(k)));
    check({t, ".cfg_done"},    32'(dn),  32'(m_done[k]));
    check({t, ".cfg_err"},     32'(er),  32'(m_err[k]));
  endtask

  bit cmp_en = 1'b0;
  int done_seen[2] = '{0, 0};

  always @(negedge clk) begin
    if (cmp_en) begin
      compare_one(0, bv_a, fr_a, grn_a, if_a.cfg_ready, if_a.cfg_done, if_a.cfg_err, busy_a);
      compare_one(1, bv_b, fr_b, grn_b, if_b.cfg_ready, if_b.cfg_done, if_b.cfg_err, busy_b);
      if (if_a.cfg_done === 1'b1) done_seen[0]++;
      if (if_b.cfg_done === 1'b1) done_seen[1]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [12:0] bv, input logic [2:0] fr);
    cfg_bv = bv;
    cfg_fr = fr;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_xmit();
    xmit_pulse = 1'b1;
    @(negedge clk);
    xmit_pulse = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      baud_clock = 1'b1;
      @(negedge clk);
      baud_clock = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int lo_a, lo_b, first_err, d0, d1;

    // Reset held for three cycles.
    reset_n = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    cyc(2);
    check("rst.a.baud_val", 32'(bv_a), 1);
    check("rst.b.baud_val", 32'(bv_b), 100);
    check("rst.b.fraction", 32'(fr_b), 0);
    check("rst.a.gen_reset_n", 32'(grn_a), 0);
    check("rst.a.cfg_ready", 32'(if_a.cfg_ready), 1);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel.a.gen_reset_n", 32'(grn_a), 1);
    check("rel.b.gen_reset_n", 32'(grn_b), 1);

    // Nominal reconfiguration with an idle line.
    request(13'd26, 3'd3);
    check("nom.a.busy", 32'(busy_a), 1);
    cyc(4);
    check("nom.a.pre_apply", 32'(bv_a), 1);
    pulse_xmit();
    lo_a = 0;
    lo_b = 0;
    repeat (8) begin
      @(negedge clk);
      if (grn_a === 1'b0) lo_a++;
      if (grn_b === 1'b0) lo_b++;
    end
    check("nom.a.restart_len", 32'(lo_a), 2);
    check("nom.b.restart_len", 32'(lo_b), 1);
    check("nom.a.baud_val", 32'(bv_a), 26);
    check("nom.a.fraction", 32'(fr_a), 3);
    check("nom.b.baud_val", 32'(bv_b), 26);
    check("nom.b.fraction", 32'(fr_b), 0);
    for (int i = 1; i <= 16; i++) begin
      baud_clock = 1'b1;
      @(negedge clk);
      baud_clock = 1'b0;
      check("nom.a.done_at_tick", 32'(if_a.cfg_done), 32'(i == 16));
      check("nom.b.done_at_tick", 32'(if_b.cfg_done), 32'(i == 4));
      if (i == 16) check("nom.a.ready_with_done", 32'(if_a.cfg_ready), 1);
      @(negedge clk);
    end

    // Transmitter busy for 500 cycles: b defers, a times out after 100.
    tx_busy = 1'b1;
    request(13'd50, 3'd6);
    for (int j = 1; j <= 500; j++) begin
      xmit_pulse = (j % 50 == 0);
      @(negedge clk);
      if (j == 100) check("defer.a.timeout_err", 32'(if_a.cfg_err), 1);
      if (j % 100 == 0) begin
        check("defer.b.busy", 32'(busy_b), 1);
        check("defer.b.baud_val", 32'(bv_b), 26);
      end
    end
    xmit_pulse = 1'b0;
    tx_busy = 1'b0;
    cyc(2);
    rx_busy = 1'b1;
    xmit_pulse = 1'b1;
    @(negedge clk);
    rx_busy = 1'b0;
    xmit_pulse = 1'b0;
    cyc(3);
    check("defer.b.no_apply_on_busy", 32'(bv_b), 26);
    pulse_xmit();
    cyc(3);
    check("defer.b.baud_val", 32'(bv_b), 50);
    check("defer.a.baud_val", 32'(bv_a), 26);
    ticks(4);

    // Receiver stuck busy: a aborts exactly 100 cycles after the transfer.
    rx_busy = 1'b1;
    request(13'd77, 3'd1);
    first_err = -1;
    for (int j = 1; j <= 120; j++) begin
      @(negedge clk);
      if (if_a.cfg_err === 1'b1 && first_err < 0) first_err = j;
    end
    check("tmo.a.err_cycle", 32'(first_err), 100);
    check("tmo.a.baud_val", 32'(bv_a), 26);
    check("tmo.a.cfg_ready", 32'(if_a.cfg_ready), 1);
    check("tmo.b.busy", 32'(busy_b), 1);
    rx_busy = 1'b0;
    cyc(2);
    pulse_xmit();
    cyc(3);
    check("tmo.b.baud_val", 32'(bv_b), 77);
    ticks(4);

    // Zero divider with a fraction: rejected by a, accepted (fraction 0) by b.
    request(13'd0, 3'd5);
    check("rej.a.err", 32'(if_a.cfg_err), 1);
    check("rej.a.cfg_ready", 32'(if_a.cfg_ready), 1);
    check("rej.b.busy", 32'(busy_b), 1);
    @(negedge clk);
    check("rej.a.err_cleared", 32'(if_a.cfg_err), 0);
    check("rej.a.baud_val", 32'(bv_a), 26);
    pulse_xmit();
    cyc(3);
    check("rej.b.baud_val", 32'(bv_b), 0);
    check("rej.b.fraction", 32'(fr_b), 0);
    ticks(4);

    // Reset during SETTLE discards the sequence.
    d0 = done_seen[0];
    d1 = done_seen[1];
    request(13'd99, 3'd7);
    cyc(2);
    pulse_xmit();
    cyc(6);
    check("mid.a.applied", 32'(bv_a), 99);
    ticks(2);
    reset_n = 1'b0;
    cyc(2);
    check("mid.a.baud_val", 32'(bv_a), 1);
    check("mid.a.fraction", 32'(fr_a), 0);
    check("mid.b.baud_val", 32'(bv_b), 100);
    reset_n = 1'b1;
    ticks(20);
    check("mid.a.no_done", 32'(done_seen[0] - d0), 0);
    check("mid.b.no_done", 32'(done_seen[1] - d1), 0);
    request(13'd13, 3'd2);
    cyc(2);
    pulse_xmit();
    cyc(6);
    ticks(16);
    check("mid.a.fresh_baud", 32'(bv_a), 13);
    check("mid.a.fresh_frac", 32'(fr_a), 2);
    check("mid.a.fresh_done", 32'(done_seen[0] - d0), 1);
    check("mid.b.fresh_done", 32'(done_seen[1] - d1), 1);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_baud_cfg_ctrl.md
Name: uart_baud_cfg_ctrl

Overview:
Run-time baud configuration sequencer for the CoreUARTapb clock generator. It accepts a new divider value and fraction over a valid/ready handshake, and waits until the UART transmitter and receiver are idle. At a transmit-bit boundary it drives the new values to the generator, pulses the generator reset to realign its divider phase, then confirms the generator is ticking before acknowledging. It sits between the APB register file and the clock generator.

Parameters:
FRCTN_EN, 0, mirrors the generator's BAUD_VAL_FRCTN_EN; when 0 the fraction output is forced to 3'b000
RESET_BAUD_VAL, 13'd1, baud_val driven out of reset
RESET_FRAC, 3'd0, fraction driven out of reset; ignored when FRCTN_EN=0
IDLE_TIMEOUT, 16'd0, maximum clk cycles spent in WAIT_IDLE before abort; 0 means wait forever
RESTART_CYCLES, 2, clk cycles gen_reset_n is held low, minimum 1
SETTLE_TICKS, 16, baud_clock pulses counted after restart before done, minimum 1

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
cfg_valid  in  1  new configuration request
cfg_ready  out  1  controller can accept a request
cfg_baud_val  in  13  requested divider value
cfg_frac  in  3  requested fraction
tx_busy  in  1  transmitter shifting or holding data
rx_busy  in  1  receiver mid-frame
xmit_pulse  in  1  from generator, one-cycle pulse per bit period
baud_clock  in  1  from generator, 16x tick
baud_val  out  13  to generator baud_val
baud_val_fraction  out  3  to generator BAUD_VAL_FRACTION
gen_reset_n  out  1  to generator reset_n, registered
cfg_done  out  1  one-cycle pulse: new config applied and settled
cfg_err  out  1  one-cycle pulse: request rejected or timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE; baud_val=RESET_BAUD_VAL; baud_val_fraction=RESET_FRAC (0 if FRCTN_EN=0); gen_reset_n=0; cfg_done=0; cfg_err=0; all counters 0; shadow registers 0.
  - gen_reset_n goes 1 on the first clk edge after reset_n returns high.
  - Reset mid-sequence discards the captured request and restores the reset values above.
- cfg_ready = (state==IDLE). busy = !cfg_ready. A transfer is cfg_valid && cfg_ready at a clk edge. cfg_valid outside IDLE is ignored.
- IDLE:
  - On transfer, capture cfg_baud_val and cfg_frac (frac forced 0 if FRCTN_EN=0) into shadow registers.
  - Reject when cfg_baud_val==0 and the effective frac!=0: cfg_err=1 for the next cycle; stay in IDLE; outputs unchanged.
  - Otherwise go to WAIT_IDLE and clear the timeout counter.
- WAIT_IDLE:
  - Timeout counter increments each cycle spent here.
  - When tx_busy==0 and rx_busy==0 in the same cycle, go to WAIT_EDGE.
  - If IDLE_TIMEOUT!=0 and the counter reaches IDLE_TIMEOUT, go to IDLE with a cfg_err pulse; generator outputs unchanged.
- WAIT_EDGE:
  - If tx_busy or rx_busy is high, return to WAIT_IDLE. The timeout counter is not cleared. Busy has priority over a simultaneous xmit_pulse.
  - Otherwise, on xmit_pulse==1, go to APPLY.
- APPLY (1 cycle):
  - On exit, baud_val<=shadow value, baud_val_fraction<=shadow fraction, gen_reset_n<=0; go to RESTART.
- RESTART:
  - gen_reset_n stays low for exactly RESTART_CYCLES clk cycles, counting from the first low cycle.
  - Then gen_reset_n<=1 and go to SETTLE with the tick counter cleared.
  - baud_clock and xmit_pulse are ignored in this state.
- SETTLE:
  - Tick counter increments on each baud_clock==1.
  - On the SETTLE_TICKS-th tick, go to IDLE with a cfg_done pulse in the cycle after that tick. cfg_ready is high in the same cycle as cfg_done.
  - No timeout in this state.
- Widths:
  - Timeout counter is 16 bits and saturates.
  - Tick counter is clog2(SETTLE_TICKS+1) bits.
  - No arithmetic on baud_val; it is passed through.
- cfg_done and cfg_err are never high in the same cycle.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release -> baud_val=1, baud_val_fraction=0, gen_reset_n=0 then 1 one cycle after release, cfg_ready=1.
- Nominal: tx_busy=rx_busy=0, write cfg_baud_val=13'd26 with cfg_frac=3 (FRCTN_EN=1) -> outputs update after the next xmit_pulse; gen_reset_n low for 2 cycles; cfg_done exactly one cycle after the 16th baud_clock.
- Busy deferral: tx_busy=1 for 500 cycles after the request -> baud_val unchanged and busy=1 throughout. Drop tx_busy -> apply happens on the first subsequent xmit_pulse. Raising rx_busy in WAIT_EDGE together with xmit_pulse -> no apply.
- Timeout: IDLE_TIMEOUT=100, rx_busy stuck at 1 -> cfg_err pulse 100 cycles after the request; baud_val still the old value; cfg_ready=1.
- Reject: cfg_baud_val=0 with cfg_frac=5 -> cfg_err the next cycle, no state change. The same request with FRCTN_EN=0 is accepted with fraction output 0.
- Mid-sequence reset: assert reset_n=0 during SETTLE -> baud_val returns to RESET_BAUD_VAL, no cfg_done, and a fresh request is accepted afterward.
